// File: rtl/addsub_ctrl_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
package addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_subtractor_n_bit.sv
// Combinational n-bit adder/subtractor: s = x + (y ^ {n{add_n}}) + add_n.
module adder_subtractor_n_bit #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] x_i,
  input  logic [n-1:0] y_i,
  input  logic         add_n_i,
  output logic [n-1:0] s_o,
  output logic         c_out_o,
  output logic         ovf_o
);

  logic [n-1:0] y_inv;
  logic [n:0]   sum;

  always_comb begin
    y_inv   = y_i ^ {n{add_n_i}};
    sum     = {1'b0, x_i} + {1'b0, y_inv} + {{n{1'b0}}, add_n_i};
    s_o     = sum[n-1:0];
    c_out_o = sum[n];
    // Overflow: operands agree in sign but the result does not.
    ovf_o   = (x_i[n-1] == y_inv[n-1]) && (sum[n-1] != x_i[n-1]);
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin front end sharing one adder_subtractor_n_bit.
// IDLE grants and latches operands, EXEC registers the result, RESP holds it.
module addsub_rr_arbiter
  import addsub_ctrl_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [n-1:0] req0_x,
  input  logic [n-1:0] req0_y,
  input  logic         req0_add_n,
  output logic         req0_ready,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  input  logic         req1_valid,
  input  logic [n-1:0] req1_x,
  input  logic [n-1:0] req1_y,
  input  logic         req1_add_n,
  output logic         req1_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [n-1:0] res_s,
  output logic         res_c_out,
  output logic         res_ovf
);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  logic [n-1:0] x_q, x_d;
  logic [n-1:0] y_q, y_d;
  logic         add_n_q, add_n_d;
  logic [n-1:0] s_q, s_d;
  logic         c_q, c_d;
  logic         ovf_q, ovf_d;

  logic         gnt_valid;
  logic         gnt_id;
  logic         resp_take;
  logic [n-1:0] alu_s;
  logic         alu_c;
  logic         alu_ovf;

  adder_subtractor_n_bit #(
    .n (n)
  ) u_alu (
    .x_i     (x_q),
    .y_i     (y_q),
    .add_n_i (add_n_q),
    .s_o     (alu_s),
    .c_out_o (alu_c),
    .ovf_o   (alu_ovf)
  );

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = REQ0;
    if (req0_valid && req1_valid) begin
      gnt_id = ptr_q;
    end else if (req1_valid) begin
      gnt_id = REQ1;
    end
  end

  always_comb begin
    resp_take = (state_q == RESP) && ((owner_q == REQ1) ? resp1_ready : resp0_ready);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    add_n_d = add_n_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_id;
          x_d     = (gnt_id == REQ1) ? req1_x : req0_x;
          y_d     = (gnt_id == REQ1) ? req1_y : req0_y;
          add_n_d = (gnt_id == REQ1) ? req1_add_n : req0_add_n;
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = alu_s;
        c_d     = alu_c;
        ovf_d   = alu_ovf;
        state_d = RESP;
      end
      RESP: begin
        if (resp_take) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= REQ0;
      owner_q <= REQ0;
      x_q     <= '0;
      y_q     <= '0;
      add_n_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      add_n_q <= add_n_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ready is gated by rst_n so it drops the moment reset is asserted.
  always_comb begin
    req0_ready  = rst_n && (state_q == IDLE) && gnt_valid && (gnt_id == REQ0);
    req1_ready  = rst_n && (state_q == IDLE) && gnt_valid && (gnt_id == REQ1);
    resp0_valid = (state_q == RESP) && (owner_q == REQ0);
    resp1_valid = (state_q == RESP) && (owner_q == REQ1);
    res_s       = s_q;
    res_c_out   = c_q;
    res_ovf     = ovf_q;
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Randomised and directed bench for addsub_rr_arbiter against a transaction-level model.
module tb_addsub_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   v = '0;
  logic [1:0]   a = '0;
  logic [1:0]   rr = '0;
  logic [N-1:0] xv [2];
  logic [N-1:0] yv [2];
  logic rdy0, rdy1, rv0, rv1;
  logic [N-1:0] s;
  logic c, o;

  int n_chk = 0;
  int n_fail = 0;

  addsub_rr_arbiter #(.n(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (v[0]),
    .req0_x      (xv[0]),
    .req0_y      (yv[0]),
    .req0_add_n  (a[0]),
    .req0_ready  (rdy0),
    .resp0_valid (rv0),
    .resp0_ready (rr[0]),
    .req1_valid  (v[1]),
    .req1_x      (xv[1]),
    .req1_y      (yv[1]),
    .req1_add_n  (a[1]),
    .req1_ready  (rdy1),
    .resp1_valid (rv1),
    .resp1_ready (rr[1]),
    .res_s       (s),
    .res_c_out   (c),
    .res_ovf     (o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {c_out, ovf, s} from plain integer and signed-range arithmetic.
  function automatic logic [5:0] ref_op(input logic [3:0] x, input logic [3:0] y, input logic sub);
    int xi, yi, sx, sy, u, r;
    logic [3:0] sv;
    logic cv, ov;
    xi = int'(x);
    yi = int'(y);
    sx = (xi >= 8) ? xi - 16 : xi;
    sy = (yi >= 8) ? yi - 16 : yi;
    if (!sub) begin
      u = xi + yi;
      r = sx + sy;
    end else begin
      u = xi + 16 - yi;
      r = sx - sy;
    end
    sv = u[3:0];
    cv = (u >= 16);
    ov = (r < -8) || (r > 7);
    return {cv, ov, sv};
  endfunction

  // Model: owner of the in-flight op (-1 = none), cycles since acceptance, fairness pointer.
  int m_owner = -1;
  int m_age = 0;
  int m_ptr = 0;
  logic [5:0] m_res = '0;

  always @(negedge clk) begin : cmp
    int g;
    int e_r0, e_r1;
    if (!rst_n) begin
      chk("rst_ready0", rdy0, 0);
      chk("rst_ready1", rdy1, 0);
      chk("rst_resp_valid", {rv0, rv1}, 0);
      chk("rst_res", {c, o, s}, 0);
      m_owner = -1;
      m_age = 0;
      m_ptr = 0;
    end else begin
      g = (v[0] && v[1]) ? m_ptr : (v[1] ? 1 : 0);
      e_r0 = (m_owner < 0 && v[g] && g == 0) ? 1 : 0;
      e_r1 = (m_owner < 0 && v[g] && g == 1) ? 1 : 0;
      chk("req0_ready", rdy0, e_r0);
      chk("req1_ready", rdy1, e_r1);
      chk("resp0_valid", rv0, (m_owner == 0 && m_age >= 2) ? 1 : 0);
      chk("resp1_valid", rv1, (m_owner == 1 && m_age >= 2) ? 1 : 0);
      if (m_owner >= 0 && m_age >= 2) chk("res", {c, o, s}, m_res);
      if (m_owner < 0) begin
        if (v[g]) begin
          m_owner = g;
          m_age = 1;
          m_res = ref_op(xv[g], yv[g], a[g]);
        end
      end else if (m_age >= 2 && rr[m_owner]) begin
        m_ptr = 1 - m_owner;
        m_owner = -1;
      end else begin
        m_age = 2;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_k(input int k);
    return (k == 1) ? rdy1 : rdy0;
  endfunction

  function automatic logic rv_k(input int k);
    return (k == 1) ? rv1 : rv0;
  endfunction

  // Issue one op from requester k and check the literal result and 2-cycle latency.
  task automatic do_op(input int k, input logic [3:0] x, input logic [3:0] y, input logic sub,
                       input logic [5:0] exp);
    int t;
    bit ok;
    v[k] = 1'b1;
    xv[k] = x;
    yv[k] = y;
    a[k] = sub;
    rr = 2'b11;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy_k(k)) ok = 1;
    end
    chk("op_grant", ok, 1);
    cyc();
    v[k] = 1'b0;
    ok = 0;
    t = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      t++;
      if (rv_k(k)) ok = 1;
    end
    chk("op_resp_seen", ok, 1);
    chk("op_latency", t, 2);
    chk("op_result", {c, o, s}, exp);
    cyc();
  endtask

  int grants [$];

  initial begin : main
    logic [5:0] held;
    bit ok;
    xv[0] = '0; xv[1] = '0; yv[0] = '0; yv[1] = '0;

    // Pin the model with hand-computed values.
    chk("pin_add", ref_op(4'd3, 4'd2, 1'b0), {1'b0, 1'b0, 4'd5});
    chk("pin_sub_ovf", ref_op(4'b1000, 4'b0001, 1'b1), {1'b1, 1'b1, 4'b0111});
    chk("pin_add_ovf", ref_op(4'd7, 4'd1, 1'b0), {1'b0, 1'b1, 4'b1000});
    chk("pin_sub_neg8", ref_op(4'd0, 4'b1000, 1'b1), {1'b0, 1'b1, 4'b1000});

    // Reset with both requesters valid.
    v = 2'b11;
    rr = 2'b11;
    repeat (3) cyc();
    chk("reset_ready", {rdy1, rdy0}, 0);
    rst_n = 1'b1;

    // Fairness: both valid continuously for 4 grants -> 0,1,0,1.
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (rdy0) grants.push_back(0);
      if (rdy1) grants.push_back(1);
      cyc();
      xv[0] = 4'($urandom); yv[0] = 4'($urandom); a[0] = 1'($urandom);
      xv[1] = 4'($urandom); yv[1] = 4'($urandom); a[1] = 1'($urandom);
    end
    v = 2'b00;
    chk("fair_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("fair_order", grants[i], i % 2);
    repeat (4) cyc();

    do_op(0, 4'd3, 4'd2, 1'b0, {1'b0, 1'b0, 4'd5});
    do_op(1, 4'b1000, 4'b0001, 1'b1, {1'b1, 1'b1, 4'b0111});
    do_op(0, 4'd7, 4'd1, 1'b0, {1'b0, 1'b1, 4'b1000});

    // Backpressure on requester 0 while requester 1 waits.
    rr = 2'b00;
    v[0] = 1'b1; xv[0] = 4'd5; yv[0] = 4'd6; a[0] = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy0) ok = 1;
    end
    chk("bp_grant0", ok, 1);
    cyc();
    v[0] = 1'b0;
    v[1] = 1'b1; xv[1] = 4'd1; yv[1] = 4'd1; a[1] = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rv0) ok = 1;
    end
    chk("bp_resp0", ok, 1);
    held = {c, o, s};
    chk("bp_result", held, {1'b0, 1'b1, 4'b1011});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rv0, 1);
      chk("bp_hold_res", {c, o, s}, held);
      chk("bp_req1_blocked", rdy1, 0);
    end
    cyc();
    rr = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req1_next", rdy1, 1);
    cyc();
    v = 2'b00;
    repeat (4) cyc();

    // Reset while an op is in EXEC.
    v[0] = 1'b1; xv[0] = 4'd9; yv[0] = 4'd4; a[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy0) ok = 1;
    end
    chk("rx_grant", ok, 1);
    cyc();
    v = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rx_async_valid", {rv1, rv0}, 0);
    chk("rx_async_ready", {rdy1, rdy0}, 0);
    chk("rx_async_res", {c, o, s}, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rx_no_stale", {rv1, rv0}, 0);
    end
    cyc();

    // Random traffic, including valids that drop before being granted.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        v[k] = ($urandom_range(0, 3) != 0);
        xv[k] = 4'($urandom);
        yv[k] = 4'($urandom);
        a[k] = 1'($urandom);
        rr[k] = ($urandom_range(0, 2) != 0);
      end
      cyc();
    end
    v = 2'b00;
    rr = 2'b11;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
